// File: rtl/button_event_port.sv
// Wishbone slave that turns raw push-button pins into debounced levels plus
// sticky press/release event flags, with a maskable level interrupt.
//
// Ports:
//   clock, reset        bus clock, synchronous active-high reset
//   buttons             raw asynchronous button pins
//   wb_cyc_i/stb_i/we_i wishbone cycle, strobe, write enable
//   wb_adr_i            word select: 0 STATE, 1 PRESS (W1C), 2 RELEASE (W1C), 3 IRQ_EN
//   wb_dat_i/wb_dat_o   write data / registered read data (0 when no ack)
//   wb_ack_o            single-cycle acknowledge
//   levels              debounced pressed state, 1 = pressed
//   interrupt           |((PRESS|RELEASE) & IRQ_EN), registered
module button_event_port #(
    parameter int unsigned NUM_BUTTONS = 3,
    parameter int unsigned SAMPLE_DIV  = 16384,
    parameter int unsigned DB_SAMPLES  = 4,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [1:0]             wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic [NUM_BUTTONS-1:0] levels,
    output logic                   interrupt
);

    localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [CNT_W-1:0]       r_presc;
    logic [DB_SAMPLES-1:0]  r_sh [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] r_levels;
    logic [NUM_BUTTONS-1:0] r_press;
    logic [NUM_BUTTONS-1:0] r_release;
    logic [NUM_BUTTONS-1:0] r_irq_en;
    logic                   r_irq;
    logic                   r_ack;
    logic [31:0]            r_dat;

    logic [NUM_BUTTONS-1:0] w_s;
    logic                   w_tick;
    logic [NUM_BUTTONS-1:0] w_lvl_nxt;
    logic [NUM_BUTTONS-1:0] w_rise;
    logic [NUM_BUTTONS-1:0] w_fall;
    logic                   w_req;
    logic                   w_wr;
    logic [NUM_BUTTONS-1:0] w_clr_press;
    logic [NUM_BUTTONS-1:0] w_clr_release;
    logic [31:0]            w_rd_data;
    logic                   w_unused_dat;

    // Synchronised pins in "pressed = 1" sense
    assign w_s    = ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_tick = (r_presc == CNT_W'(SAMPLE_DIV - 1));

    // Level changes only once the whole sample window agrees
    always_comb begin
        w_lvl_nxt = r_levels;
        for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
            if (&r_sh[i]) begin
                w_lvl_nxt[i] = 1'b1;
            end else if (~|r_sh[i]) begin
                w_lvl_nxt[i] = 1'b0;
            end
        end
    end

    assign w_rise = w_lvl_nxt & ~r_levels;
    assign w_fall = ~w_lvl_nxt & r_levels;

    // Bus decode; a request is accepted only on the cycle its ack is generated
    assign w_req         = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr          = w_req & wb_we_i;
    assign w_clr_press   = (w_wr && wb_adr_i == 2'd1) ? wb_dat_i[NUM_BUTTONS-1:0] : '0;
    assign w_clr_release = (w_wr && wb_adr_i == 2'd2) ? wb_dat_i[NUM_BUTTONS-1:0] : '0;
    assign w_unused_dat  = ^wb_dat_i;

    always_comb begin
        w_rd_data = 32'd0;
        case (wb_adr_i)
            2'd0:    w_rd_data = 32'(r_levels);
            2'd1:    w_rd_data = 32'(r_press);
            2'd2:    w_rd_data = 32'(r_release);
            default: w_rd_data = 32'(r_irq_en);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_presc   <= '0;
            for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
                r_sh[i] <= '0;
            end
            r_levels  <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_irq_en  <= '0;
            r_irq     <= 1'b0;
            r_ack     <= 1'b0;
            r_dat     <= 32'd0;
        end else begin
            r_sync1 <= buttons;
            r_sync2 <= r_sync1;
            r_presc <= w_tick ? '0 : r_presc + CNT_W'(1);
            if (w_tick) begin
                for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
                    r_sh[i] <= {r_sh[i][DB_SAMPLES-2:0], w_s[i]};
                end
            end
            r_levels  <= w_lvl_nxt;
            // Event set takes priority over a same-cycle software clear
            r_press   <= (r_press & ~w_clr_press) | w_rise;
            r_release <= (r_release & ~w_clr_release) | w_fall;
            if (w_wr && wb_adr_i == 2'd3) begin
                r_irq_en <= wb_dat_i[NUM_BUTTONS-1:0];
            end
            r_irq <= |((r_press | r_release) & r_irq_en);
            r_ack <= w_req;
            r_dat <= (w_req && !wb_we_i) ? w_rd_data : 32'd0;
        end
    end

    assign wb_dat_o  = r_dat;
    assign wb_ack_o  = r_ack;
    assign levels    = r_levels;
    assign interrupt = r_irq;

endmodule

// File: tb/tb_button_event_port.sv
// Bench for button_event_port: directed scenarios plus randomized pins and bus
// traffic, compared every cycle against a run-length behavioural model.
module tb_button_event_port;

    localparam int unsigned NB  = 3;
    localparam int unsigned DIV = 4;
    localparam int unsigned DB  = 4;

    logic          clock;
    logic          reset;
    logic [NB-1:0] buttons;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [1:0]    wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [NB-1:0] levels;
    logic          interrupt;

    int tests_run;
    int tests_failed;

    button_event_port #(
        .NUM_BUTTONS(NB),
        .SAMPLE_DIV (DIV),
        .DB_SAMPLES (DB),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .buttons  (buttons),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .levels   (levels),
        .interrupt(interrupt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: pin pipeline as a queue, debounce as a run length
    int unsigned   m_n;
    logic [NB-1:0] m_pin_q[$];
    bit   [NB-1:0] m_last;
    int            m_run [NB];
    logic [NB-1:0] m_lvl, m_press, m_rel, m_irqen;
    logic          m_irq, m_ack;
    logic [31:0]   m_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit   [NB-1:0] s;
        logic [NB-1:0] new_lvl, clr_p, clr_r;
        logic [31:0]   rd;
        logic          req;
        if (reset) begin
            m_n = 0;
            m_pin_q = {NB'(0), NB'(0)};
            m_last = '0;
            for (int i = 0; i < int'(NB); i++) m_run[i] = DB;
            m_lvl = '0; m_press = '0; m_rel = '0; m_irqen = '0;
            m_irq = 1'b0; m_ack = 1'b0; m_dat = 32'd0;
            return;
        end
        s = ~m_pin_q[0];
        for (int i = 0; i < int'(NB); i++)
            new_lvl[i] = (m_run[i] >= int'(DB)) ? m_last[i] : m_lvl[i];
        req = wb_cyc_i & wb_stb_i & ~m_ack;
        case (wb_adr_i)
            2'd0:    rd = 32'(m_lvl);
            2'd1:    rd = 32'(m_press);
            2'd2:    rd = 32'(m_rel);
            default: rd = 32'(m_irqen);
        endcase
        clr_p = (req && wb_we_i && wb_adr_i == 2'd1) ? wb_dat_i[NB-1:0] : '0;
        clr_r = (req && wb_we_i && wb_adr_i == 2'd2) ? wb_dat_i[NB-1:0] : '0;
        m_irq   = |((m_press | m_rel) & m_irqen);
        m_press = (m_press & ~clr_p) | (new_lvl & ~m_lvl);
        m_rel   = (m_rel & ~clr_r) | (~new_lvl & m_lvl);
        if (req && wb_we_i && wb_adr_i == 2'd3) m_irqen = wb_dat_i[NB-1:0];
        m_dat = (req && !wb_we_i) ? rd : 32'd0;
        m_ack = req;
        m_lvl = new_lvl;
        if ((m_n % DIV) == DIV - 1) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (s[i] == m_last[i]) begin
                    if (m_run[i] < int'(DB)) m_run[i]++;
                end else begin
                    m_last[i] = s[i];
                    m_run[i]  = 1;
                end
            end
        end
        m_pin_q.push_back(buttons);
        void'(m_pin_q.pop_front());
        m_n++;
    endtask

    // One clock: model follows the edge, DUT compared on the falling edge
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        chk("cyc_levels", 32'(levels), 32'(m_lvl));
        chk("cyc_irq", 32'(interrupt), 32'(m_irq));
        chk("cyc_ack", 32'(wb_ack_o), 32'(m_ack));
        chk("cyc_dat", wb_dat_o, m_dat);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
        step();
        chk({tag, "_ack"}, 32'(wb_ack_o), 32'd1);
        chk(tag, wb_dat_o, exp);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
        step();
        chk("wr_ack", 32'(wb_ack_o), 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        step();
    endtask

    task automatic wait_level(input int idx, input logic val, input string tag);
        int k;
        k = 0;
        while (levels[idx] !== val && k < 64) begin
            step();
            k++;
        end
        chk(tag, 32'(levels[idx]), 32'(val));
    endtask

    initial begin
        int  k;
        bit  hit;
        int  hold;
        tests_run = 0;
        tests_failed = 0;
        buttons = 3'b111;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 2'd0; wb_dat_i = 32'd0;

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_levels", 32'(levels), 32'd0);
        chk("rst_irq", 32'(interrupt), 32'd0);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        bus_read(2'd0, 32'd0, "rst_state");
        bus_read(2'd1, 32'd0, "rst_press");
        bus_read(2'd2, 32'd0, "rst_release");
        bus_read(2'd3, 32'd0, "rst_irqen");

        // Press button 1 and measure latency to the debounced level
        buttons[1] = 1'b0;
        k = 0;
        while (levels[1] !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("press_latency_in_window", 32'(k >= 14 && k <= 19), 32'd1);
        chk("press_levels", 32'(levels), 32'h2);
        bus_read(2'd1, 32'h2, "press_flag");
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, 32'h0, "press_cleared");

        // Short glitch on button 0 never reaches the level
        buttons[0] = 1'b0;
        repeat (3) step();
        buttons[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            chk("glitch_level0", 32'(levels[0]), 32'd0);
        end
        bus_read(2'd1, 32'h0, "glitch_press");

        // Interrupt on button 0 press and release
        buttons[1] = 1'b1;
        wait_level(1, 1'b0, "release_b1");
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, 32'h0, "release_cleared");
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, 32'h1, "irqen_rd");
        buttons[0] = 1'b0;
        wait_level(0, 1'b1, "press_b0");
        chk("irq_not_early", 32'(interrupt), 32'd0);
        step();
        chk("irq_one_after_press", 32'(interrupt), 32'd1);
        bus_read(2'd1, 32'h1, "irq_press_flag");
        buttons[0] = 1'b1;
        wait_level(0, 1'b0, "release_b0");
        bus_read(2'd2, 32'h1, "irq_release_flag");
        bus_write(2'd1, 32'h1);
        chk("irq_held_by_release", 32'(interrupt), 32'd1);
        bus_write(2'd2, 32'h1);
        chk("irq_cleared", 32'(interrupt), 32'd0);

        // W1C of PRESS[2] lands on the edge where levels[2] rises
        buttons[2] = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 64 && !hit; c++) begin
            if (m_run[2] >= int'(DB) && m_last[2] && !m_lvl[2]) begin
                wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
                wb_adr_i = 2'd1; wb_dat_i = 32'h4;
                step();
                chk("collide_ack", 32'(wb_ack_o), 32'd1);
                chk("collide_level", 32'(levels[2]), 32'd1);
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
                step();
                hit = 1'b1;
            end else begin
                step();
            end
        end
        chk("collide_reached", 32'(hit), 32'd1);
        bus_read(2'd1, 32'h4, "collide_press");

        // Reset arriving with a read strobe
        buttons = 3'b111;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd0;
        reset = 1'b1;
        step();
        chk("rstrd_no_ack", 32'(wb_ack_o), 32'd0);
        reset = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
        chk("rstrd_no_ack2", 32'(wb_ack_o), 32'd0);
        chk("rstrd_levels", 32'(levels), 32'd0);
        chk("rstrd_irq", 32'(interrupt), 32'd0);
        bus_read(2'd1, 32'd0, "rstrd_press");
        bus_read(2'd2, 32'd0, "rstrd_release");
        bus_read(2'd3, 32'd0, "rstrd_irqen");

        // Randomized pins and bus traffic against the model
        for (int seg = 0; seg < 80; seg++) begin
            buttons = NB'($urandom);
            hold = int'($urandom_range(1, 30));
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
                    wb_we_i  = 1'($urandom);
                    wb_adr_i = 2'($urandom);
                    wb_dat_i = $urandom;
                end else begin
                    wb_cyc_i = 1'($urandom_range(0, 3) == 0);
                    wb_stb_i = 1'b0;
                end
                reset = ($urandom_range(0, 299) == 0);
                step();
            end
        end
        reset = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
